ex_muldiv_unit: RTL and testbench
=================================

# ex_muldiv_unit

Iterative RV32M multiply/divide unit attached to the execute stage. It is the multicycle path behind the EX stage's multicycle-busy hook. It accepts one operation at a time, holds EX via `busy`, and presents a held result until the pipeline accepts it. Width and bits-per-cycle are parametrised, and it supports flush/kill mid-operation.

## Interface
- `XLEN`, default 32: operand and result width. Must be a multiple of `UNROLL`.
- `UNROLL`, default 1: iteration steps per cycle. Legal values are 1, 2, 4, 8.
- `clk` input, 1: clock.
- `reset_n` input, 1: reset; asynchronous, active-low.
- `start` input, 1: a valid mul/div op is present in EX this cycle.
- `kill` input, 1: flush of EX; aborts any op in flight.
- `op` input, 3, `md_op_e`: MUL=0, MULH=1, MULHSU=2, MULHU=3, DIV=4, DIVU=5, REM=6, REMU=7 (funct3 encoding).
- `op_a` input, XLEN: rs1 value.
- `op_b` input, XLEN: rs2 value.
- `result_ack` input, 1: downstream takes the result (ready_mem & ~stall).
- `busy` output, 1: operation in progress; EX must not advance.
- `result_valid` output, 1: `result` is valid and held.
- `result` output, XLEN: final product or quotient/remainder.

## Operation
- FSM states: IDLE, CALC, FIX, DONE.
- IDLE: `start & ~kill` latches op, operands and sign flags.
  - Special case, divide by zero: go to DONE with quotient = all ones and remainder = op_a.
  - Special case, signed overflow (op_a = most-negative, op_b = -1, DIV/REM): go to DONE with quotient = op_a and remainder = 0.
  - Otherwise go to CALC with counter = XLEN/UNROLL.
- CALC: performs UNROLL steps per cycle and decrements the counter. At counter = 1 it goes to FIX.
  - Multiply: unsigned shift-add on magnitudes into a 2·XLEN accumulator.
  - Divide: restoring division on magnitudes.
- FIX: applies sign correction, then selects the result and registers it.
  - MUL: low half. MULH, MULHSU, MULHU: high half.
  - Signed ops use two's-complement magnitudes. MULHSU treats op_b as unsigned.
  - Quotient is negative iff the operand signs differ (signed DIV). Remainder takes the dividend's sign.
  - Goes to DONE.
- DONE: holds `result`.
  - `result_ack` alone goes to IDLE.
  - `result_ack & start & ~kill` accepts the new op directly, with the same branching as IDLE.
- `kill` in any state: next state is IDLE and `result_valid` drops. `kill` has priority over `start` and `result_ack`. `result` keeps its last value.
- `start` in CALC or FIX is ignored. EX is stalled by `busy`.
- Counter width is $clog2(XLEN/UNROLL+1).

## Timing
- Reset values: state IDLE, `busy` 0, `result_valid` 0, `result` 0, counter 0, internal accumulators 0.
- `busy` = CALC | FIX, registered from state. `result_valid` = DONE.
- Normal latency: `start` sampled at edge 0, CALC occupies edges 1..N with N = XLEN/UNROLL, FIX at edge N+1, `result_valid` high after edge N+2.
  - XLEN=32, UNROLL=1: 34 cycles.
  - XLEN=32, UNROLL=4: 10 cycles.
- Special cases: `result_valid` is high one cycle after `start`, and `busy` never rises.
- `result` is stable for the whole DONE interval and changes only on the FIX→DONE edge or a special-case entry.
- Throughput, back-to-back: a new op can start on the same edge the previous result is acked.
- Reset asserted mid-operation: all state clears immediately; no result is produced.

## Structure
- Package `riscv_pkg` holds:
  - `md_op_e` (3-bit enum).
  - `md_state_e` (IDLE/CALC/FIX/DONE).
  - The MD funct3 constants.
- Sub-module `md_step`: one combinational radix-2 step, either shift-add or a restoring subtract selected by mode. It is instantiated UNROLL times in a generate chain.
- The top level holds the FSM, counter, operand and sign registers, and the FIX logic.

## Test plan
- MUL 7 × −3 (XLEN=32, UNROLL=1): result 0xFFFFFFEB. `result_valid` rises 34 cycles after `start`, and `busy` is high for exactly 33 cycles.
- High-half products:
  - MULH 0x80000000 × 0x80000000 gives 0x40000000.
  - MULHSU 0xFFFFFFFF × 2 gives 0xFFFFFFFF.
  - MULHU 0xFFFFFFFF × 0xFFFFFFFF gives 0xFFFFFFFE.
- Division:
  - DIV −7/2 gives 0xFFFFFFFD; REM −7/2 gives 0xFFFFFFFF.
  - DIVU 100/7 gives 14; REMU 100/7 gives 2.
- Edge cases:
  - DIV 5/0 gives 0xFFFFFFFF and REM 5/0 gives 5, both valid 1 cycle after `start` with `busy` never high.
  - DIV 0x80000000/0xFFFFFFFF gives 0x80000000 and REM gives 0.
- Kill:
  - `kill` in CALC cycle 10 makes `busy` low next cycle, and `result_valid` never rises.
  - `start` and `kill` in the same cycle: the op is not accepted.
  - A subsequent DIVU 100/7 still returns 14.
- Handshake:
  - Hold `result_ack` low for 5 cycles in DONE: `result` is unchanged.
  - Ack with a simultaneous `start` of MUL 3×3: returns 9 after 34 cycles.
  - Reset mid-CALC: all outputs 0.
  - Repeat MUL 7×−3 with UNROLL=4: latency 10.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32M encodings for the execute-stage multiply/divide unit.
package riscv_pkg;

    typedef enum logic [2:0] {
        MD_MUL    = 3'd0,
        MD_MULH   = 3'd1,
        MD_MULHSU = 3'd2,
        MD_MULHU  = 3'd3,
        MD_DIV    = 3'd4,
        MD_DIVU   = 3'd5,
        MD_REM    = 3'd6,
        MD_REMU   = 3'd7
    } md_op_e;

    typedef enum logic [1:0] {
        MD_IDLE,
        MD_CALC,
        MD_FIX,
        MD_DONE
    } md_state_e;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

endpackage

// File: rtl/md_step.sv
// One radix-2 iteration: shift-add multiply (mode=0) or restoring divide (mode=1)
// on a {hi, lo} accumulator.
module md_step #(
    parameter int XLEN = 32
) (
    input  logic              mode,
    input  logic [2*XLEN-1:0] acc_in,
    input  logic [XLEN-1:0]   opnd,
    output logic [2*XLEN-1:0] acc_out
);

    logic [XLEN:0]   sum;
    logic [XLEN:0]   rem_sh;
    logic [XLEN-1:0] rem_sub;
    logic            ge;

    always_comb begin
        sum     = {1'b0, acc_in[2*XLEN-1:XLEN]} + {1'b0, (acc_in[0] ? opnd : {XLEN{1'b0}})};
        // Partial remainder never exceeds 2*divisor, so XLEN+1 bits suffice.
        rem_sh  = acc_in[2*XLEN-1:XLEN-1];
        ge      = rem_sh >= {1'b0, opnd};
        rem_sub = rem_sh[XLEN-1:0] - opnd;
        if (mode)
            acc_out = ge ? {rem_sub, acc_in[XLEN-2:0], 1'b1}
                         : {rem_sh[XLEN-1:0], acc_in[XLEN-2:0], 1'b0};
        else
            acc_out = {sum, acc_in[XLEN-1:1]};
    end

endmodule

// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide behind the EX multicycle-busy hook.
// Works on magnitudes, sign-corrects in FIX, holds the result until acked.
module ex_muldiv_unit
    import riscv_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int UNROLL = 1
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            start,
    input  logic            kill,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            result_ack,
    output logic            busy,
    output logic            result_valid,
    output logic [XLEN-1:0] result
);

    localparam int N  = XLEN / UNROLL;
    localparam int CW = $clog2(N + 1);

    md_state_e         state;
    logic [CW-1:0]     cnt;
    logic [2*XLEN-1:0] acc;
    logic [XLEN-1:0]   opnd;
    logic [2:0]        op_q;
    logic              neg_q;

    md_op_e            op_e;
    logic              is_div, is_rem, a_neg, b_neg, div_zero, div_ovf, accept;
    logic [XLEN-1:0]   mag_a, mag_b, spec_res, init_opnd;
    logic [2*XLEN-1:0] init_acc;
    logic              init_neg;

    always_comb begin
        op_e      = md_op_e'(op);
        is_div    = op[2];
        is_rem    = (op_e == MD_REM) || (op_e == MD_REMU);
        a_neg     = op_a[XLEN-1] && (op_e == MD_MULH || op_e == MD_MULHSU ||
                                     op_e == MD_DIV  || op_e == MD_REM);
        b_neg     = op_b[XLEN-1] && (op_e == MD_MULH || op_e == MD_DIV || op_e == MD_REM);
        mag_a     = a_neg ? -op_a : op_a;
        mag_b     = b_neg ? -op_b : op_b;
        div_zero  = is_div && (op_b == {XLEN{1'b0}});
        div_ovf   = (op_e == MD_DIV || op_e == MD_REM) &&
                    (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (&op_b);
        spec_res  = div_zero ? (is_rem ? op_a : {XLEN{1'b1}})
                             : (is_rem ? {XLEN{1'b0}} : op_a);
        // Divide keeps the dividend in the low half; multiply keeps the multiplier there.
        init_acc  = {{XLEN{1'b0}}, (is_div ? mag_a : mag_b)};
        init_opnd = is_div ? mag_b : mag_a;
        init_neg  = is_rem ? a_neg : (a_neg ^ b_neg);
        accept    = start && !kill &&
                    (state == MD_IDLE || (state == MD_DONE && result_ack));
    end

    logic [UNROLL:0][2*XLEN-1:0] chain;
    assign chain[0] = acc;

    for (genvar i = 0; i < UNROLL; i++) begin : g_step
        md_step #(.XLEN(XLEN)) u_step (
            .mode    (op_q[2]),
            .acc_in  (chain[i]),
            .opnd    (opnd),
            .acc_out (chain[i+1])
        );
    end

    logic [2*XLEN-1:0] fix_prod;
    logic [XLEN-1:0]   fix_div, fix_res;

    always_comb begin
        fix_prod = neg_q ? -acc : acc;
        fix_div  = (op_q == F3_REM || op_q == F3_REMU) ? acc[2*XLEN-1:XLEN] : acc[XLEN-1:0];
        if (op_q[2])
            fix_res = neg_q ? -fix_div : fix_div;
        else
            fix_res = (op_q == F3_MUL) ? fix_prod[XLEN-1:0] : fix_prod[2*XLEN-1:XLEN];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= MD_IDLE;
            cnt          <= '0;
            acc          <= '0;
            opnd         <= '0;
            op_q         <= '0;
            neg_q        <= 1'b0;
            busy         <= 1'b0;
            result_valid <= 1'b0;
            result       <= '0;
        end else if (kill) begin
            state        <= MD_IDLE;
            busy         <= 1'b0;
            result_valid <= 1'b0;
        end else begin
            case (state)
                MD_IDLE, MD_DONE: begin
                    if (accept) begin
                        op_q  <= op;
                        neg_q <= init_neg;
                        acc   <= init_acc;
                        opnd  <= init_opnd;
                        if (div_zero || div_ovf) begin
                            state        <= MD_DONE;
                            result       <= spec_res;
                            result_valid <= 1'b1;
                            busy         <= 1'b0;
                        end else begin
                            state        <= MD_CALC;
                            cnt          <= CW'(N);
                            result_valid <= 1'b0;
                            busy         <= 1'b1;
                        end
                    end else if (state == MD_DONE && result_ack) begin
                        state        <= MD_IDLE;
                        result_valid <= 1'b0;
                    end
                end
                MD_CALC: begin
                    acc <= chain[UNROLL];
                    cnt <= cnt - 1'b1;
                    if (cnt == CW'(1))
                        state <= MD_FIX;
                end
                MD_FIX: begin
                    result       <= fix_res;
                    state        <= MD_DONE;
                    busy         <= 1'b0;
                    result_valid <= 1'b1;
                end
                default: state <= MD_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Bench for ex_muldiv_unit: UNROLL=1 and UNROLL=4 instances share stimulus;
// directed vectors, hand sequences and random ops against an arithmetic model.
module tb_ex_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        kill = 1'b0;
    logic        result_ack = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic        busy1, rv1, busy4, rv4;
    logic [31:0] res1, res4;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    ex_muldiv_unit #(.XLEN(32), .UNROLL(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .start(start), .kill(kill), .op(op),
        .op_a(op_a), .op_b(op_b), .result_ack(result_ack),
        .busy(busy1), .result_valid(rv1), .result(res1)
    );

    ex_muldiv_unit #(.XLEN(32), .UNROLL(4)) dut4 (
        .clk(clk), .reset_n(reset_n), .start(start), .kill(kill), .op(op),
        .op_a(op_a), .op_b(op_b), .result_ack(result_ack),
        .busy(busy4), .result_valid(rv4), .result(res4)
    );

    function automatic logic [31:0] ref_md(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb;
        logic [63:0] p;
        logic        ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (o)
            3'd0: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * longint'({32'b0, b}); return p[63:32]; end
            3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'(sa / sb);
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: return (b == 0) ? a : ovf ? 32'h0 : 32'(sa % sb);
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Ops that resolve without iterating: any divide by zero, signed overflow.
    function automatic logic is_special(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        return (o == 3'd4 || o == 3'd5 || o == 3'd6 || o == 3'd7) &&
               ((b == 0) || ((o == 3'd4 || o == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issue one op (optionally with ack of a held result) and wait until both units report.
    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic with_ack, output int l1, output int l4,
                          output int b1, output int b4, output logic [31:0] r1, output logic [31:0] r4);
        op = o; op_a = a; op_b = b; start = 1'b1; result_ack = with_ack;
        l1 = -1; l4 = -1; b1 = 0; b4 = 0; r1 = '0; r4 = '0;
        for (int c = 1; c <= 100 && (l1 < 0 || l4 < 0); c++) begin
            @(posedge clk); #1;
            if (c == 1) begin start = 1'b0; result_ack = 1'b0; end
            if (busy1) b1++;
            if (busy4) b4++;
            if (rv1 && l1 < 0) begin l1 = c; r1 = res1; end
            if (rv4 && l4 < 0) begin l4 = c; r4 = res4; end
        end
    endtask

    task automatic ack_res();
        result_ack = 1'b1;
        @(posedge clk); #1;
        result_ack = 1'b0;
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vt[14];

    initial begin
        int          l1, l4, b1, b4, seen;
        logic [31:0] r1, r4, held;
        logic [2:0]  o;
        logic [31:0] a, b;
        int          el1, el4;

        vt[0]  = '{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 34};
        vt[1]  = '{3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 34};
        vt[2]  = '{3'd2, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF, 34};
        vt[3]  = '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 34};
        vt[4]  = '{3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 34};
        vt[5]  = '{3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 34};
        vt[6]  = '{3'd5, 32'd100,        32'd7,         32'd14,        34};
        vt[7]  = '{3'd7, 32'd100,        32'd7,         32'd2,         34};
        vt[8]  = '{3'd4, 32'd5,          32'd0,         32'hFFFF_FFFF, 1};
        vt[9]  = '{3'd6, 32'd5,          32'd0,         32'd5,         1};
        vt[10] = '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1};
        vt[11] = '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1};
        vt[12] = '{3'd5, 32'd9,          32'd0,         32'hFFFF_FFFF, 1};
        vt[13] = '{3'd7, 32'd9,          32'd0,         32'd9,         1};

        repeat (3) @(posedge clk);
        #1;
        chk("reset busy1", {31'b0, busy1}, 32'd0);
        chk("reset rv1", {31'b0, rv1}, 32'd0);
        chk("reset res1", res1, 32'd0);
        chk("reset busy4", {31'b0, busy4}, 32'd0);
        chk("reset rv4", {31'b0, rv4}, 32'd0);
        chk("reset res4", res4, 32'd0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        foreach (vt[i]) begin
            run_op(vt[i].op, vt[i].a, vt[i].b, 1'b0, l1, l4, b1, b4, r1, r4);
            el4 = (vt[i].lat == 1) ? 1 : 10;
            chk($sformatf("vec%0d res u1", i), r1, vt[i].exp);
            chk($sformatf("vec%0d res u4", i), r4, vt[i].exp);
            chk($sformatf("vec%0d lat u1", i), 32'(l1), 32'(vt[i].lat));
            chk($sformatf("vec%0d lat u4", i), 32'(l4), 32'(el4));
            chk($sformatf("vec%0d busy u1", i), 32'(b1), 32'(vt[i].lat - 1));
            chk($sformatf("vec%0d busy u4", i), 32'(b4), 32'(el4 - 1));
            ack_res();
        end

        // Kill mid-CALC: both units in CALC at edge 5.
        op = 3'd0; op_a = 32'd11; op_b = 32'd13; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        repeat (4) @(posedge clk);
        #1; kill = 1'b1;
        @(posedge clk); #1; kill = 1'b0;
        chk("kill busy1", {31'b0, busy1}, 32'd0);
        chk("kill busy4", {31'b0, busy4}, 32'd0);
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (rv1 || rv4 || busy1 || busy4) seen++;
        end
        chk("kill no result", 32'(seen), 32'd0);

        // start together with kill is not accepted.
        op = 3'd5; op_a = 32'd100; op_b = 32'd7; start = 1'b1; kill = 1'b1;
        @(posedge clk); #1; start = 1'b0; kill = 1'b0;
        seen = 0;
        repeat (5) begin
            if (rv1 || rv4 || busy1 || busy4) seen++;
            @(posedge clk); #1;
        end
        chk("start+kill ignored", 32'(seen), 32'd0);
        run_op(3'd5, 32'd100, 32'd7, 1'b0, l1, l4, b1, b4, r1, r4);
        chk("divu after kill u1", r1, 32'd14);
        chk("divu after kill u4", r4, 32'd14);
        ack_res();

        // Result held through 5 un-acked cycles, then ack+start back-to-back.
        run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, l1, l4, b1, b4, r1, r4);
        held = r1;
        chk("hold initial", held, 32'hFFFF_FFFE);
        seen = 0;
        repeat (5) begin
            @(posedge clk); #1;
            if (res1 !== held || !rv1 || res4 !== held || !rv4) seen++;
        end
        chk("hold stable", 32'(seen), 32'd0);
        run_op(3'd0, 32'd3, 32'd3, 1'b1, l1, l4, b1, b4, r1, r4);
        chk("b2b res u1", r1, 32'd9);
        chk("b2b lat u1", 32'(l1), 32'd34);
        chk("b2b res u4", r4, 32'd9);
        chk("b2b lat u4", 32'(l4), 32'd10);
        ack_res();

        // Reset during CALC clears everything, including the held 9.
        op = 3'd0; op_a = 32'd7; op_b = 32'd5; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        repeat (5) @(posedge clk);
        #1; reset_n = 1'b0;
        #1;
        chk("rst busy1", {31'b0, busy1}, 32'd0);
        chk("rst rv1", {31'b0, rv1}, 32'd0);
        chk("rst res1", res1, 32'd0);
        chk("rst busy4", {31'b0, busy4}, 32'd0);
        chk("rst res4", res4, 32'd0);
        @(posedge clk); #1; reset_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 40; i++) begin
            o = 3'($urandom_range(0, 7));
            a = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: b = 32'hFFFF_FFFF;
                2: b = 32'($urandom_range(1, 300));
                default: b = $urandom;
            endcase
            el1 = is_special(o, a, b) ? 1 : 34;
            el4 = is_special(o, a, b) ? 1 : 10;
            run_op(o, a, b, 1'b0, l1, l4, b1, b4, r1, r4);
            chk($sformatf("rnd%0d op%0d %h %h u1", i, o, a, b), r1, ref_md(o, a, b));
            chk($sformatf("rnd%0d op%0d %h %h u4", i, o, a, b), r4, ref_md(o, a, b));
            chk($sformatf("rnd%0d lat u1", i), 32'(l1), 32'(el1));
            chk($sformatf("rnd%0d lat u4", i), 32'(l4), 32'(el4));
            ack_res();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
